// File: rtl/if_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : if_prefetch_unit
// Brief    : Instruction-fetch stage with a DEPTH-entry prefetch buffer,
//            one outstanding synchronous-SRAM read and redirect flush.
// Revision : 1.0 - initial release
// ============================================================================
module if_prefetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h1c000000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_sram_en,
  output logic        inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        ds_allowin,
  output logic        fs_to_ds_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst,
  output logic        fs_adef
);

  localparam int            AW      = $clog2(DEPTH);
  localparam int            PW      = AW + 1;
  localparam logic [PW:0]   DEPTH_W = (PW + 1)'(DEPTH);

  // Control state
  logic          run_q, run_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          req_pending_q, req_pending_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          req_adef_q, req_adef_d;
  logic          halted_q, halted_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;

  // Buffer storage (contents are only meaningful between the pointers)
  logic [31:0]   buf_pc_q   [DEPTH];
  logic [31:0]   buf_inst_q [DEPTH];
  logic          buf_adef_q [DEPTH];

  logic [AW-1:0] w_rd_idx;
  logic [AW-1:0] w_wr_idx;
  logic [PW-1:0] w_count;
  logic [PW:0]   w_occ;
  logic          w_valid;
  logic          w_pop;
  logic          w_redirect;
  logic          w_issue_seq;
  logic          w_capture;
  logic [31:0]   w_target_aligned;

  assign w_rd_idx         = rd_ptr_q[AW-1:0];
  assign w_wr_idx         = wr_ptr_q[AW-1:0];
  assign w_count          = wr_ptr_q - rd_ptr_q;
  assign w_valid          = run_q & (wr_ptr_q != rd_ptr_q);
  assign w_pop            = w_valid & ds_allowin;
  assign w_redirect       = run_q & br_taken;
  assign w_target_aligned = {br_target[31:2], 2'b00};
  // Occupancy seen by the issue check: buffered + in flight - leaving now
  assign w_occ            = {1'b0, w_count} + (PW + 1)'(req_pending_q) - (PW + 1)'(w_pop);
  assign w_issue_seq      = run_q & ~br_taken & ~halted_q & (w_occ < DEPTH_W);
  // A response landing in a redirect cycle belongs to the flushed stream
  assign w_capture        = run_q & req_pending_q & ~br_taken;

  // SRAM request and decode-facing outputs
  always_comb begin
    inst_sram_en    = w_redirect | w_issue_seq;
    inst_sram_we    = 1'b0;
    inst_sram_wdata = 32'h0;
    inst_sram_addr  = 32'h0;
    if (w_redirect) begin
      inst_sram_addr = w_target_aligned;
    end else if (w_issue_seq) begin
      inst_sram_addr = fetch_pc_q;
    end
    fs_to_ds_valid = w_valid;
    fs_pc          = w_valid ? buf_pc_q[w_rd_idx]   : 32'h0;
    fs_inst        = w_valid ? buf_inst_q[w_rd_idx] : 32'h0;
    fs_adef        = w_valid ? buf_adef_q[w_rd_idx] : 1'b0;
  end

  // Next-state: redirect overrides sequential issue and response capture
  always_comb begin
    run_d         = 1'b1;
    fetch_pc_d    = fetch_pc_q;
    req_pending_d = req_pending_q;
    req_pc_d      = req_pc_q;
    req_adef_d    = req_adef_q;
    halted_d      = halted_q;
    rd_ptr_d      = rd_ptr_q + PW'(w_pop);
    wr_ptr_d      = wr_ptr_q + PW'(w_capture);
    if (run_q) begin
      if (w_capture) begin
        req_pending_d = 1'b0;
      end
      if (w_redirect) begin
        rd_ptr_d      = wr_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        req_pending_d = 1'b1;
        req_pc_d      = br_target;
        req_adef_d    = (br_target[1:0] != 2'b00);
        halted_d      = (br_target[1:0] != 2'b00);
        fetch_pc_d    = w_target_aligned + 32'd4;
      end else if (w_issue_seq) begin
        req_pending_d = 1'b1;
        req_pc_d      = fetch_pc_q;
        req_adef_d    = 1'b0;
        fetch_pc_d    = fetch_pc_q + 32'd4;
      end
    end
  end

  // Control state register with asynchronous reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run_q         <= 1'b0;
      fetch_pc_q    <= RESET_PC;
      req_pending_q <= 1'b0;
      req_pc_q      <= 32'h0;
      req_adef_q    <= 1'b0;
      halted_q      <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      run_q         <= run_d;
      fetch_pc_q    <= fetch_pc_d;
      req_pending_q <= req_pending_d;
      req_pc_q      <= req_pc_d;
      req_adef_q    <= req_adef_d;
      halted_q      <= halted_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // Buffer write of the returning instruction at the tail slot
  always_ff @(posedge clk) begin
    if (w_capture) begin
      buf_pc_q[w_wr_idx]   <= req_pc_q;
      buf_inst_q[w_wr_idx] <= inst_sram_rdata;
      buf_adef_q[w_wr_idx] <= req_adef_q;
    end
  end

endmodule
`default_nettype wire

// File: doc/if_prefetch_unit.md
# if_prefetch_unit

Parametrised instruction-fetch stage with a prefetch buffer. It replaces the single-cycle `pc`/`nextpc` logic of the first-generation core. It drives the synchronous instruction SRAM, tracks one outstanding read, and queues up to `DEPTH` fetched instructions. It presents them to decode over a valid/allowin handshake, and accepts branch/exception redirects that flush all prefetched state.

## Interface
Parameters:
- `RESET_PC`, default `32'h1c000000`: first fetch address after reset.
- `DEPTH`, default `4`: prefetch buffer entries. Must be a power of two and ≥2.

Ports:
- `clk` in 1: sole clock. All state updates on the rising edge.
- `resetn` in 1: reset. Asynchronous, active-low.
- `inst_sram_en` in/out: out 1: read request this cycle.
- `inst_sram_we` out 1: tied 0.
- `inst_sram_addr` out 32: word-aligned read address (bits [1:0] always 0).
- `inst_sram_wdata` out 32: tied 0.
- `inst_sram_rdata` in 32: read data. Valid the cycle after the request.
- `br_taken` in 1: redirect request from decode/exception logic.
- `br_target` in 32: redirect address. Sampled only when `br_taken`=1.
- `ds_allowin` in 1: decode accepts an entry this cycle.
- `fs_to_ds_valid` out 1: buffer head valid.
- `fs_pc` out 32: PC of the head entry. 0 when not valid.
- `fs_inst` out 32: instruction of the head entry. 0 when not valid.
- `fs_adef` out 1: head entry carries an address-misalignment exception. 0 when not valid.

## Operation
- State:
  - `run` flag.
  - `fetch_pc` (next sequential address).
  - `req_pending` plus `req_pc`/`req_adef` of the outstanding read.
  - `halted` flag.
  - Circular buffer of `DEPTH` × {pc[31:0], inst[31:0], adef}.
  - Read/write pointers of log2(DEPTH)+1 bits. Full/empty are derived from the pointers.
- `run` clears on reset and sets on the first rising edge with `resetn`=1. While `run`=0: `inst_sram_en`=0 and no state changes.
- `pop` = `fs_to_ds_valid` & `ds_allowin`. The head advances on the edge.
- Response capture: when `req_pending`=1, at the edge the buffer writes {`req_pc`, `inst_sram_rdata`, `req_adef`} and `req_pending` clears. Exception: in a redirect cycle the response is discarded.
- Sequential issue, when `run` & ~`br_taken` & ~`halted` & (count + `req_pending` − `pop` < `DEPTH`):
  - `inst_sram_en`=1 and `inst_sram_addr`=`fetch_pc`.
  - At the edge: `req_pending`←1, `req_pc`←`fetch_pc`, `req_adef`←0, `fetch_pc`←`fetch_pc`+4 (mod 2^32 wrap).
- Redirect (`br_taken`=1, `run`=1) has priority over everything:
  - The buffer is flushed; pointers are equalised at the edge. An entry popped in the same cycle counts as consumed.
  - Any response arriving this cycle is dropped.
  - `inst_sram_en`=1 with `inst_sram_addr`={`br_target`[31:2],2'b00}.
  - At the edge: `req_pending`←1, `req_pc`←`br_target`, `fetch_pc`←aligned target+4.
- Misaligned target (`br_target`[1:0]≠0): `req_adef`←1 and `halted`←1.
  - The entry is still delivered with `fs_adef`=1 and `fs_pc` equal to the unaligned target.
  - No sequential issue occurs while `halted`=1. Only a later `br_taken` clears `halted` and resumes fetch.
- Invariant: count + `req_pending` ≤ `DEPTH` at all times. Entries leave in issue order, with no duplication and no loss.

## Timing
- Reset (asynchronous): all outputs except tied-off ones go to 0 immediately, without waiting for an edge. State resets to: `fetch_pc`=`RESET_PC`, buffer empty, `req_pending`=0, `halted`=0, `run`=0.
- Post-reset sequence (cycle 0 = first edge with `resetn` high, which sets `run`):
  - Cycle 1: request to `RESET_PC`.
  - Cycle 2: data returns.
  - Cycle 3: `fs_to_ds_valid`=1 with `fs_pc`=`RESET_PC`.
- Steady-state throughput is 1 instruction/cycle for any `DEPTH`≥2 with `ds_allowin`=1.
- Redirect latency: `br_taken` in cycle N gives target request in cycle N, data in N+1, and `fs_to_ds_valid` with `fs_pc`=target in N+2. Cycles N+1 and earlier never present post-flush stale entries.
- Reset asserted mid-request: the outstanding read is forgotten. The SRAM response arriving after reset release is ignored because `req_pending`=0.

## Test plan
- Reset release, `ds_allowin`=1, SRAM returns data = address → `fs_pc` 0x1c000000, 0x1c000004, 0x1c000008… on consecutive cycles starting cycle 3, with `fs_inst`=`fs_pc`.
- `ds_allowin`=0 for 10 cycles (`DEPTH`=4) → `inst_sram_en` drops once 4 entries are buffered or in flight. On release, entries arrive in order with no gaps, drops or duplicates.
- `br_taken` with target 0x1c000100 while a read is pending and 3 entries are buffered → stale data discarded, `fs_to_ds_valid`=0 for cycles N+1 and N+2's edge-in state, `fs_pc`=0x1c000100 at N+2, then 0x1c000104.
- `br_taken` with target 0x1c000102 → single entry with `fs_adef`=1 and `fs_pc`=0x1c000102, `inst_sram_en`=0 afterwards. A later redirect to 0x1c000200 resumes fetch.
- `resetn` dropped asynchronously mid-stream (between edges) → `fs_to_ds_valid` and `inst_sram_en` go to 0 before the next edge. Restart repeats the post-reset sequence from `RESET_PC`.
- `DEPTH`=2 and `DEPTH`=8 builds, random `ds_allowin` and random redirects, scoreboard against a reference PC model → every delivered (pc, inst) matches program order and the occupancy bound holds.
